// File: rtl/debounce_pkg.sv
// Shared types and helpers for the push-button front end.
package debounce_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, polarity normalisation,
// tick-based debounce with press/release pulses and hold-to-repeat FSM.
//
// state      | meaning
// -----------+------------------------------------------------------
// RPT_IDLE   | button released, or auto-repeat disabled for channel
// RPT_DELAY  | pressed, counting ticks up to the first repeat pulse
// RPT_REPEAT | still held, emitting a repeat pulse every period
//
// "release" and "repeat" are language keywords, so the pulse outputs
// carry an _evt suffix.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_TICKS      = 10,
  parameter int REPEAT_DELAY_TICKS  = 500,
  parameter int REPEAT_PERIOD_TICKS = 100,
  parameter bit ACTIVE_LOW          = 1'b1,
  parameter bit REPEAT_EN           = 1'b1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press,
  output logic release_evt,
  output logic repeat_evt
);

  localparam int DW   = cnt_w(DEBOUNCE_TICKS);
  localparam int RMAX = (REPEAT_DELAY_TICKS > REPEAT_PERIOD_TICKS) ?
                        REPEAT_DELAY_TICKS : REPEAT_PERIOD_TICKS;
  localparam int RW   = cnt_w(RMAX);

  localparam logic [DW-1:0] D_LAST   = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY_TICKS - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD_TICKS - 1);

  logic          sync1, sync2;
  logic          act;
  logic [DW-1:0] dcnt;
  logic          accept, rise, fall;
  rpt_state_t    state;
  logic [RW-1:0] rcnt;
  logic          rpt_fire;

  // Synchroniser; resets to the idle pin level so a held button is seen fresh.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1 <= ACTIVE_LOW;
      sync2 <= ACTIVE_LOW;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign act    = sync2 ^ ACTIVE_LOW;
  assign accept = tick && (act != level) && (dcnt == D_LAST);
  assign rise   = accept && act;
  assign fall   = accept && !act;

  // Debounce counter: any agreeing cycle restarts the disagreement run.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      dcnt        <= '0;
      level       <= 1'b0;
      press       <= 1'b0;
      release_evt <= 1'b0;
    end else begin
      press       <= rise;
      release_evt <= fall;
      if (act == level) begin
        dcnt <= '0;
      end else if (tick) begin
        if (dcnt == D_LAST) begin
          level <= act;
          dcnt  <= '0;
        end else begin
          dcnt <= dcnt + 1'b1;
        end
      end
    end
  end

  // Repeat pulse decode; a coinciding release suppresses it.
  always_comb begin
    rpt_fire = 1'b0;
    if (tick && !fall) begin
      case (state)
        RPT_DELAY:  rpt_fire = (rcnt == DLY_LAST);
        RPT_REPEAT: rpt_fire = (rcnt == PER_LAST);
        default:    rpt_fire = 1'b0;
      endcase
    end
  end

  // Repeat FSM and its tick counter.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= RPT_IDLE;
      rcnt       <= '0;
      repeat_evt <= 1'b0;
    end else begin
      repeat_evt <= rpt_fire;
      if (fall) begin
        state <= RPT_IDLE;
        rcnt  <= '0;
      end else begin
        case (state)
          RPT_IDLE: begin
            if (rise && REPEAT_EN) begin
              state <= RPT_DELAY;
              rcnt  <= '0;
            end
          end
          RPT_DELAY: begin
            if (tick) begin
              if (rcnt == DLY_LAST) begin
                state <= RPT_REPEAT;
                rcnt  <= '0;
              end else begin
                rcnt <= rcnt + 1'b1;
              end
            end
          end
          RPT_REPEAT: begin
            if (tick) begin
              if (rcnt == PER_LAST) rcnt <= '0;
              else                  rcnt <= rcnt + 1'b1;
            end
          end
          default: begin
            state <= RPT_IDLE;
            rcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel button front end: shared tick prescaler plus N_CH
// independent debounce/auto-repeat channels feeding the LCD control logic.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH                = 4,
  parameter int CLK_FREQ            = 50000000,
  parameter int TICK_HZ             = 1000,
  parameter int DEBOUNCE_TICKS      = 10,
  parameter int REPEAT_DELAY_TICKS  = 500,
  parameter int REPEAT_PERIOD_TICKS = 100,
  parameter bit ACTIVE_LOW          = 1'b1,
  parameter     REPEAT_EN           = {N_CH{1'b1}}
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [N_CH-1:0] raw,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_evt,
  output logic [N_CH-1:0] repeat_evt,
  output logic [N_CH-1:0] key_event,
  output logic            tick
);

  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int PW  = cnt_w(DIV);
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("debounce_bank: CLK_FREQ/TICK_HZ must be at least 2");
  end
  if (DEBOUNCE_TICKS < 1 || REPEAT_DELAY_TICKS < 1 || REPEAT_PERIOD_TICKS < 1) begin : g_bad_ticks
    $error("debounce_bank: all *_TICKS parameters must be at least 1");
  end
  if ($bits(REPEAT_EN) != N_CH) begin : g_bad_mask
    $error("debounce_bank: REPEAT_EN width must equal N_CH");
  end

  logic [PW-1:0] pcnt;

  // Prescaler wraps at DIV-1; tick is high for that one count.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)              pcnt <= '0;
    else if (pcnt == P_LAST) pcnt <= '0;
    else                     pcnt <= pcnt + 1'b1;
  end

  assign tick = (pcnt == P_LAST);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_TICKS      (DEBOUNCE_TICKS),
      .REPEAT_DELAY_TICKS  (REPEAT_DELAY_TICKS),
      .REPEAT_PERIOD_TICKS (REPEAT_PERIOD_TICKS),
      .ACTIVE_LOW          (ACTIVE_LOW),
      .REPEAT_EN           (REPEAT_EN[i])
    ) u_ch (
      .CLK         (CLK),
      .RESET       (RESET),
      .tick        (tick),
      .raw         (raw[i]),
      .level       (level[i]),
      .press       (press[i]),
      .release_evt (release_evt[i]),
      .repeat_evt  (repeat_evt[i])
    );
  end

  assign key_event = press | repeat_evt;

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: rule-level model compared every cycle, plus
// hand-computed timing/count expectations per test phase.
module tb_debounce_bank;

  localparam int N_CH = 4;
  localparam int DIV  = 10;
  localparam int DB   = 3;
  localparam int DLY  = 5;
  localparam int PER  = 2;
  localparam logic [N_CH-1:0] EN = 4'b1011;

  logic            CLK   = 1'b0;
  logic            RESET = 1'b0;
  logic [N_CH-1:0] raw   = '0;
  logic [N_CH-1:0] level, press, release_evt, repeat_evt, key_event;
  logic            tick;

  debounce_bank #(
    .N_CH                (N_CH),
    .CLK_FREQ            (1000),
    .TICK_HZ             (100),
    .DEBOUNCE_TICKS      (DB),
    .REPEAT_DELAY_TICKS  (DLY),
    .REPEAT_PERIOD_TICKS (PER),
    .ACTIVE_LOW          (1'b1),
    .REPEAT_EN           (EN)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .raw         (raw),
    .level       (level),
    .press       (press),
    .release_evt (release_evt),
    .repeat_evt  (repeat_evt),
    .key_event   (key_event),
    .tick        (tick)
  );

  always #5 CLK = ~CLK;

  int cyc   = 0;
  int phase = 0;
  int n_vec = 0;
  int n_err = 0;

  initial begin : cycle_count
    forever begin
      @(posedge CLK);
      cyc++;
    end
  end

  // ---------------- behavioural model ----------------
  logic [N_CH-1:0] m_d1 = '1, m_d2 = '1;
  logic [N_CH-1:0] m_lvl = '0, m_prs = '0, m_rel = '0, m_rpt = '0, m_armed = '0;
  int m_run [N_CH];
  int m_held[N_CH];
  int m_pc = 0;

  initial begin : model
    logic tk, act;
    forever begin
      @(posedge CLK or negedge RESET);
      if (!RESET) begin
        m_pc = 0;
        m_d1 = '1; m_d2 = '1;
        m_lvl = '0; m_prs = '0; m_rel = '0; m_rpt = '0; m_armed = '0;
        for (int c = 0; c < N_CH; c++) begin
          m_run[c] = 0;
          m_held[c] = 0;
        end
      end else begin
        tk   = (m_pc == DIV - 1);
        m_pc = (m_pc + 1) % DIV;
        for (int c = 0; c < N_CH; c++) begin
          act = ~m_d2[c];
          m_prs[c] = 1'b0; m_rel[c] = 1'b0; m_rpt[c] = 1'b0;
          if (act == m_lvl[c]) m_run[c] = 0;
          else if (tk) begin
            m_run[c]++;
            if (m_run[c] == DB) begin
              m_run[c] = 0;
              m_lvl[c] = act;
              m_prs[c] = act;
              m_rel[c] = ~act;
            end
          end
          if (m_rel[c]) m_armed[c] = 1'b0;
          else if (m_prs[c]) begin
            m_armed[c] = EN[c];
            m_held[c]  = 0;
          end else if (tk && m_armed[c]) begin
            m_held[c]++;
            if (m_held[c] == DLY || (m_held[c] > DLY && (m_held[c] - DLY) % PER == 0))
              m_rpt[c] = 1'b1;
          end
        end
        m_d2 = m_d1;
        m_d1 = raw;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  initial begin : monitor
    logic [5*N_CH:0] got, exp;
    int cur_phase, phase_start, rel_start, last_tick, lat;
    bit rel_pending, want_first_tick;
    int n_prs[N_CH], n_rel[N_CH], n_rpt[N_CH], first_prs[N_CH], last_ev[N_CH], n_since[N_CH];
    int n_tick, n_pulse;
    cur_phase = 0; phase_start = 0; rel_start = 0; last_tick = -1;
    rel_pending = 1'b1; want_first_tick = 1'b0; n_tick = 0; n_pulse = 0;
    for (int c = 0; c < N_CH; c++) begin
      n_prs[c] = 0; n_rel[c] = 0; n_rpt[c] = 0; first_prs[c] = -1;
      last_ev[c] = 0; n_since[c] = 0;
    end
    forever begin
      @(negedge CLK);
      exp = {m_lvl, m_prs, m_rel, m_rpt, m_prs | m_rpt, (m_pc == DIV - 1)};
      got = {level, press, release_evt, repeat_evt, key_event, tick};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL cycle %0d outputs: got lvl=%b prs=%b rel=%b rpt=%b key=%b tick=%b, expected lvl=%b prs=%b rel=%b rpt=%b key=%b tick=%b",
                 cyc, level, press, release_evt, repeat_evt, key_event, tick,
                 m_lvl, m_prs, m_rel, m_rpt, m_prs | m_rpt, (m_pc == DIV - 1));
      end

      if (phase != cur_phase) begin
        case (cur_phase)
          1: begin
            chk("ticks_during_reset", n_tick, 0);
            chk("pulses_during_reset", n_pulse, 0);
          end
          3: begin
            lat = first_prs[0] - phase_start + 1;
            chk("press0_count", n_prs[0], 1);
            chk("press0_latency_22_to_32", (first_prs[0] >= 0 && lat >= 22 && lat <= 32) ? 1 : 0, 1);
          end
          4: begin
            chk("release0_count", n_rel[0], 1);
            chk("no_press0_on_release", n_prs[0], 0);
          end
          5: begin
            chk("bounce_press0", n_prs[0], 0);
            chk("bounce_release0", n_rel[0], 0);
          end
          6: chk("press0_after_bounce", n_prs[0], 1);
          7: begin
            chk("press1_count", n_prs[1], 1);
            chk("repeat1_at_least_6", (n_rpt[1] >= 6) ? 1 : 0, 1);
            chk("press2_count", n_prs[2], 1);
            chk("repeat2_masked", n_rpt[2], 0);
            chk("press3_count", n_prs[3], 1);
          end
          8: begin
            chk("release1_count", n_rel[1], 1);
            chk("repeat1_suppressed_on_release", n_rpt[1], 2);
            chk("release2_count", n_rel[2], 1);
          end
          9: begin
            chk("press1_again", n_prs[1], 1);
            chk("repeat1_running", (n_rpt[1] >= 2) ? 1 : 0, 1);
          end
          11: begin
            chk("press1_after_reset", n_prs[1], 1);
            chk("press1_after_reset_offset", first_prs[1] - phase_start, 29);
            chk("repeat1_restart_count", n_rpt[1], 1);
          end
          default: ;
        endcase
        cur_phase   = phase;
        phase_start = cyc;
        n_tick = 0; n_pulse = 0;
        for (int c = 0; c < N_CH; c++) begin
          n_prs[c] = 0; n_rel[c] = 0; n_rpt[c] = 0; first_prs[c] = -1;
        end
        if (phase == 10) chk("level_repeat_cleared_by_reset", int'({level, repeat_evt}), 0);
      end

      if (!RESET) begin
        rel_pending = 1'b1;
        last_tick   = -1;
      end else if (rel_pending) begin
        rel_pending     = 1'b0;
        rel_start       = cyc;
        want_first_tick = 1'b1;
      end

      if (tick) begin
        n_tick++;
        if (want_first_tick) begin
          chk("first_tick_after_reset", cyc - rel_start, 8);
          want_first_tick = 1'b0;
        end
        if (last_tick >= 0) chk("tick_spacing", cyc - last_tick, 10);
        last_tick = cyc;
      end

      for (int c = 0; c < N_CH; c++) begin
        n_pulse += int'(press[c]) + int'(release_evt[c]) + int'(repeat_evt[c]);
        n_prs[c] += int'(press[c]);
        n_rel[c] += int'(release_evt[c]);
        n_rpt[c] += int'(repeat_evt[c]);
        if (press[c]) begin
          if (first_prs[c] < 0) first_prs[c] = cyc;
          last_ev[c] = cyc;
          n_since[c] = 0;
        end
        if (repeat_evt[c]) begin
          chk($sformatf("repeat%0d_spacing", c), cyc - last_ev[c], (n_since[c] == 0) ? 50 : 20);
          last_ev[c] = cyc;
          n_since[c]++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge CLK);
    #2;
  endtask

  initial begin : stim
    RESET = 1'b0; raw = 4'b0000; phase = 1;
    step(30);
    raw = 4'b1111; RESET = 1'b1; phase = 2;
    step(40);
    raw[0] = 1'b0; phase = 3;
    step(60);
    raw[0] = 1'b1; phase = 4;
    step(60);
    phase = 5;
    for (int k = 0; k < 13; k++) begin
      raw[0] = (k % 2 == 0) ? 1'b0 : 1'b1;
      step(15);
    end
    raw[0] = 1'b1;
    step(20);
    raw[0] = 1'b0; phase = 6;
    step(60);
    raw = 4'b0001; phase = 7;
    step(240);
    raw[2] = 1'b1; phase = 8;
    for (int k = 0; k < 60; k++) begin
      @(negedge CLK);
      if (repeat_evt[1]) break;
    end
    step(15);
    raw[1] = 1'b1;
    step(40);
    raw[1] = 1'b0; phase = 9;
    step(120);
    @(posedge CLK);
    #3;
    RESET = 1'b0; phase = 10;
    step(20);
    RESET = 1'b1; phase = 11;
    step(90);
    phase = 12;
    step(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
